// File: rtl/jump_sequencer_pkg.sv
// Shared definitions for the jump sequencer: turn states, block sides and
// the default landing timeout.
package jump_sequencer_pkg;

  typedef enum logic [2:0] {
    S_WAIT_IN = 3'd0,
    S_JUMP    = 3'd1,
    S_SCROLL  = 3'd2,
    S_FALL    = 3'd3,
    S_OVER    = 3'd4
  } state_t;

  localparam logic SIDE_LEFT  = 1'b0;
  localparam logic SIDE_RIGHT = 1'b1;

  // Nominal jump is about 6.24 M cycles at 40 MHz; allow some margin.
  localparam int unsigned DEF_LAND_TIMEOUT = 8_000_000;

endpackage

// File: rtl/landing_watchdog.sv
// Landing watchdog: counts cycles while enabled, cleared on demand, and
// flags expiry once the count reaches LAND_TIMEOUT-1 (then holds there).
module landing_watchdog
  import jump_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_W    = 24,
  parameter int unsigned LAND_TIMEOUT = DEF_LAND_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(LAND_TIMEOUT - 1);

  logic [TIMEOUT_W-1:0] count_q;
  logic [TIMEOUT_W-1:0] count_d;

  // Next count: clear wins, otherwise count up and stick at the limit.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LIMIT)) begin
      count_d = count_q + TIMEOUT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LIMIT);

endmodule

// File: rtl/jump_sequencer.sv
// Game-turn controller: turns button requests into one character command
// per turn, waits for landing, then triggers a block scroll. Tracks score,
// game-over and a landing watchdog.
module jump_sequencer
  import jump_sequencer_pkg::*;
#(
  parameter int unsigned SCORE_W      = 10,
  parameter int unsigned SCORE_MAX    = 999,
  parameter int unsigned TIMEOUT_W    = 24,
  parameter int unsigned LAND_TIMEOUT = DEF_LAND_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               module_en,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               next_side,
  input  logic               landed,
  input  logic               scroll_done,
  output logic               jump_left,
  output logic               jump_right,
  output logic               jump_fail,
  output logic               scroll_start,
  output logic [SCORE_W-1:0] score,
  output logic               game_over,
  output logic               busy
);

  localparam logic [SCORE_W-1:0] SCORE_SAT = SCORE_W'(SCORE_MAX);

  state_t             state_q, state_d;
  logic               jump_left_q, jump_left_d;
  logic               jump_right_q, jump_right_d;
  logic               jump_fail_q, jump_fail_d;
  logic               scroll_start_q, scroll_start_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               game_over_q, game_over_d;
  logic               busy_q, busy_d;

  logic soft_rst;
  logic wd_clear;
  logic wd_enable;
  logic wd_expired;

  assign soft_rst = rst | ~module_en;

  landing_watchdog #(
    .TIMEOUT_W   (TIMEOUT_W),
    .LAND_TIMEOUT(LAND_TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (soft_rst),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  // Next-state and registered-output logic for one game turn.
  always_comb begin
    state_d        = state_q;
    jump_left_d    = 1'b0;
    jump_right_d   = 1'b0;
    jump_fail_d    = 1'b0;
    scroll_start_d = 1'b0;
    score_d        = score_q;
    game_over_d    = game_over_q;
    wd_clear       = 1'b0;
    wd_enable      = (state_q == S_JUMP) || (state_q == S_FALL);

    case (state_q)
      S_WAIT_IN: begin
        if (btn_left ^ btn_right) begin
          wd_clear = 1'b1;
          if ((btn_left && (next_side == SIDE_LEFT)) ||
              (btn_right && (next_side == SIDE_RIGHT))) begin
            jump_left_d  = btn_left;
            jump_right_d = btn_right;
            state_d      = S_JUMP;
          end else begin
            jump_fail_d = 1'b1;
            state_d     = S_FALL;
          end
        end else if (btn_left && btn_right) begin
          // Ambiguous request counts as a wrong guess.
          wd_clear    = 1'b1;
          jump_fail_d = 1'b1;
          state_d     = S_FALL;
        end
      end
      S_JUMP: begin
        // landed takes priority over a coincident timeout.
        if (landed) begin
          score_d        = (score_q == SCORE_SAT) ? score_q : score_q + SCORE_W'(1);
          scroll_start_d = 1'b1;
          state_d        = S_SCROLL;
        end else if (wd_expired) begin
          game_over_d = 1'b1;
          state_d     = S_OVER;
        end
      end
      S_SCROLL: begin
        if (scroll_done) begin
          state_d = S_WAIT_IN;
        end
      end
      S_FALL: begin
        if (landed || wd_expired) begin
          game_over_d = 1'b1;
          state_d     = S_OVER;
        end
      end
      S_OVER: begin
        state_d = S_OVER;
      end
      default: begin
        state_d = S_WAIT_IN;
      end
    endcase

    busy_d = (state_d != S_WAIT_IN);
  end

  // State and output registers; module_en low behaves as reset.
  always_ff @(posedge clk) begin
    if (soft_rst) begin
      state_q        <= S_WAIT_IN;
      jump_left_q    <= 1'b0;
      jump_right_q   <= 1'b0;
      jump_fail_q    <= 1'b0;
      scroll_start_q <= 1'b0;
      score_q        <= '0;
      game_over_q    <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      jump_left_q    <= jump_left_d;
      jump_right_q   <= jump_right_d;
      jump_fail_q    <= jump_fail_d;
      scroll_start_q <= scroll_start_d;
      score_q        <= score_d;
      game_over_q    <= game_over_d;
      busy_q         <= busy_d;
    end
  end

  assign jump_left    = jump_left_q;
  assign jump_right   = jump_right_q;
  assign jump_fail    = jump_fail_q;
  assign scroll_start = scroll_start_q;
  assign score        = score_q;
  assign game_over    = game_over_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_jump_sequencer.sv
// Self-checking bench for jump_sequencer: a turn-level model checked every
// cycle, plus directed literal checks on key moments of each scenario.
module tb_jump_sequencer;

  localparam int unsigned SCORE_W      = 10;
  localparam int unsigned SCORE_MAX    = 3;
  localparam int unsigned LAND_TIMEOUT = 100;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               module_en = 1'b1;
  logic               btn_left = 1'b0;
  logic               btn_right = 1'b0;
  logic               next_side = 1'b0;
  logic               landed = 1'b0;
  logic               scroll_done = 1'b0;
  logic               jump_left, jump_right, jump_fail, scroll_start;
  logic [SCORE_W-1:0] score;
  logic               game_over, busy;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  jump_sequencer #(
    .SCORE_W     (SCORE_W),
    .SCORE_MAX   (SCORE_MAX),
    .TIMEOUT_W   (24),
    .LAND_TIMEOUT(LAND_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .module_en   (module_en),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .next_side   (next_side),
    .landed      (landed),
    .scroll_done (scroll_done),
    .jump_left   (jump_left),
    .jump_right  (jump_right),
    .jump_fail   (jump_fail),
    .scroll_start(scroll_start),
    .score       (score),
    .game_over   (game_over),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Turn-level model: who is in the air, whether a scroll is pending,
  // whether the game is lost, and how long the character has been airborne.
  int m_score = 0;
  int m_air   = 0;   // 0 grounded, 1 good jump, 2 falling
  int m_t     = 0;
  bit m_scroll = 0;
  bit m_dead   = 0;
  bit e_jl = 0, e_jr = 0, e_jf = 0, e_ss = 0, e_go = 0, e_busy = 0;

  always @(posedge clk) begin
    e_jl = 0; e_jr = 0; e_jf = 0; e_ss = 0;
    if (rst || !module_en) begin
      m_score = 0; m_air = 0; m_t = 0; m_scroll = 0; m_dead = 0;
    end else if (m_dead) begin
      // game lost: nothing happens
    end else if (m_air != 0) begin
      if (landed) begin
        if (m_air == 1) begin
          m_score  = (m_score < SCORE_MAX) ? m_score + 1 : m_score;
          e_ss     = 1;
          m_scroll = 1;
        end else begin
          m_dead = 1;
        end
        m_air = 0;
      end else if (m_t == LAND_TIMEOUT - 1) begin
        m_dead = 1;
        m_air  = 0;
      end else begin
        m_t++;
      end
    end else if (m_scroll) begin
      if (scroll_done) m_scroll = 0;
    end else if (btn_left || btn_right) begin
      if ((btn_left != btn_right) && (btn_right == next_side)) begin
        e_jl  = btn_left;
        e_jr  = btn_right;
        m_air = 1;
      end else begin
        e_jf  = 1;
        m_air = 2;
      end
      m_t = 0;
    end
    e_go   = m_dead;
    e_busy = m_dead || m_scroll || (m_air != 0);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the clock edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_jump_left",    int'(jump_left),    int'(e_jl));
      check("m_jump_right",   int'(jump_right),   int'(e_jr));
      check("m_jump_fail",    int'(jump_fail),    int'(e_jf));
      check("m_scroll_start", int'(scroll_start), int'(e_ss));
      check("m_score",        int'(score),        m_score);
      check("m_game_over",    int'(game_over),    int'(e_go));
      check("m_busy",         int'(busy),         int'(e_busy));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  int exp_scores [5] = '{1, 2, 3, 3, 3};
  int found;

  initial begin
    cyc(3);
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_busy", int'(busy), 0);
    check("rst_score", int'(score), 0);
    check("rst_game_over", int'(game_over), 0);

    // Correct jump to the right.
    next_side = 1'b1;
    btn_right = 1'b1; cyc(1); btn_right = 1'b0;
    check("ok_jump_right", int'(jump_right), 1);
    check("ok_busy", int'(busy), 1);
    cyc(49);
    landed = 1'b1; cyc(1); landed = 1'b0;
    check("ok_score", int'(score), 1);
    check("ok_scroll_start", int'(scroll_start), 1);
    cyc(5);
    scroll_done = 1'b1; cyc(1); scroll_done = 1'b0;
    check("ok_idle", int'(busy), 0);
    cyc(2);

    // Wrong side, then landing ends the game; later buttons are dead.
    next_side = 1'b0;
    btn_right = 1'b1; cyc(1); btn_right = 1'b0;
    check("wrong_fail", int'(jump_fail), 1);
    check("wrong_no_right", int'(jump_right), 0);
    cyc(10);
    landed = 1'b1; cyc(1); landed = 1'b0;
    check("wrong_game_over", int'(game_over), 1);
    btn_left = 1'b1; cyc(1); btn_left = 1'b0;
    check("over_no_left", int'(jump_left), 0);
    cyc(5);

    // Simultaneous buttons: fail only; no landing lets the watchdog end it.
    do_reset();
    check("reset_clears_over", int'(game_over), 0);
    next_side = 1'b1;
    btn_left = 1'b1; btn_right = 1'b1; cyc(1); btn_left = 1'b0; btn_right = 1'b0;
    check("both_fail", int'(jump_fail), 1);
    check("both_no_left", int'(jump_left), 0);
    check("both_no_right", int'(jump_right), 0);
    cyc(110);
    check("fall_timeout_over", int'(game_over), 1);

    // Five turns with ignored buttons while busy; score saturates at 3.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      next_side = (i % 2 == 1);
      if (next_side) btn_right = 1'b1; else btn_left = 1'b1;
      cyc(1);
      btn_left = 1'b0; btn_right = 1'b0;
      check("turn_pulse", int'(next_side ? jump_right : jump_left), 1);
      cyc(3);
      btn_left = 1'b1; cyc(1); btn_left = 1'b0;
      btn_right = 1'b1; cyc(1); btn_right = 1'b0;
      cyc(8);
      landed = 1'b1; cyc(1); landed = 1'b0;
      check("turn_score", int'(score), exp_scores[i]);
      btn_right = 1'b1; btn_left = 1'b1; cyc(1); btn_right = 1'b0; btn_left = 1'b0;
      landed = 1'b1; cyc(1); landed = 1'b0;
      cyc(2);
      scroll_done = 1'b1; cyc(1); scroll_done = 1'b0;
    end
    check("sat_final_score", int'(score), 3);

    // Watchdog on a good jump: game over exactly 100 cycles after the pulse.
    do_reset();
    next_side = 1'b0;
    btn_left = 1'b1; cyc(1); btn_left = 1'b0;
    check("wd_jump_left", int'(jump_left), 1);
    found = -1;
    for (int k = 1; k <= 120; k++) begin
      cyc(1);
      if (game_over) begin
        found = k;
        break;
      end
    end
    check("wd_cycle", found, 100);
    check("wd_score", int'(score), 0);

    // module_en low mid-jump clears everything; then a normal jump.
    do_reset();
    next_side = 1'b1;
    btn_right = 1'b1; cyc(1); btn_right = 1'b0;
    cyc(5);
    module_en = 1'b0; cyc(1);
    check("en_busy", int'(busy), 0);
    check("en_game_over", int'(game_over), 0);
    check("en_pulses", int'({jump_left, jump_right, jump_fail, scroll_start}), 0);
    landed = 1'b1; cyc(1); landed = 1'b0;
    module_en = 1'b1; cyc(1);
    next_side = 1'b0;
    btn_left = 1'b1; cyc(1); btn_left = 1'b0;
    check("en_jump_left", int'(jump_left), 1);
    cyc(20);
    landed = 1'b1; cyc(1); landed = 1'b0;
    check("en_score", int'(score), 1);
    scroll_done = 1'b1; cyc(1); scroll_done = 1'b0;
    cyc(3);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end

endmodule
